// File: rtl/correlator_pkg.sv
// rtl/correlator_pkg.sv - shared constants, baud divider and parser states for the command receiver
// Ports: none (package).
package correlator_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] CMD_SET_INT   = 8'h01;
  localparam logic [7:0] CMD_SET_MASK  = 8'h02;
  localparam logic [7:0] CMD_SET_DELAY = 8'h03;
  localparam logic [7:0] CMD_CLEAR     = 8'h04;

  // Clock cycles per UART bit, integer-truncated.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [1:0] {
    P_SYNC,
    P_CMD,
    P_DATA,
    P_SUM
  } parser_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with 2-FF input synchroniser
// Ports: clk, rst_n (sync active-low), rx (async line, idle high),
//        byte_data (received byte), byte_valid (1-cycle, good stop bit),
//        byte_ferr (1-cycle, stop bit sampled low).
module uart_rx_byte
  import correlator_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_e;

  byte_state_e   state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          byte_ferr_q, byte_ferr_d;
  logic          fall;

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_ferr_d  = 1'b0;
    // prev must be high: a line held low produces no further edges.
    fall         = prev_q & ~sync2_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d        = '0;
          byte_valid_d = sync2_q;
          byte_ferr_d  = ~sync2_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_ferr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_ferr_q  <= byte_ferr_d;
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign byte_ferr  = byte_ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART command frame parser driving correlator configuration registers
// Ports: clk, rst_n (sync active-low), RX (async UART line),
//        integration_time, input_enable, delay_sel (config registers),
//        counters_clear, frame_valid, frame_error (1-cycle pulses).
// Frame: A5, CMD, D3, D2, D1, D0, CHK with CHK = CMD^D3^D2^D1^D0.
module uart_cmd_rx
  import correlator_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400,
  parameter int NUM_INPUTS    = 12,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX,
  output logic [31:0]           integration_time,
  output logic [NUM_INPUTS-1:0] input_enable,
  output logic [7:0]            delay_sel,
  output logic                  counters_clear,
  output logic                  frame_valid,
  output logic                  frame_error
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int GW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYCLES);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ferr;

  uart_rx_byte #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RX),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  parser_state_e         state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [31:0]           value_q, value_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            chk_q, chk_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [31:0]           it_q, it_d;
  logic [NUM_INPUTS-1:0] ie_q, ie_d;
  logic [7:0]            ds_q, ds_d;
  logic                  clr_q, clr_d;
  logic                  fv_q, fv_d;
  logic                  fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    it_d    = it_q;
    ie_d    = ie_q;
    ds_d    = ds_q;
    clr_d   = 1'b0;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    // Saturating inter-byte gap counter.
    if (byte_valid)              gap_d = '0;
    else if (gap_q == GAP_LIMIT) gap_d = gap_q;
    else                         gap_d = gap_q + GW'(1);

    if (byte_valid) begin
      case (state_q)
        P_SYNC: if (byte_data == SYNC_BYTE) state_d = P_CMD;
        P_CMD: begin
          cmd_d   = byte_data;
          chk_d   = byte_data;
          cnt_d   = 2'd3;
          state_d = P_DATA;
        end
        P_DATA: begin
          value_d = {value_q[23:0], byte_data};
          chk_d   = chk_q ^ byte_data;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd0) state_d = P_SUM;
        end
        P_SUM: begin
          state_d = P_SYNC;
          if (byte_data != chk_q) begin
            fe_d = 1'b1;
          end else begin
            case (cmd_q)
              CMD_SET_INT: begin
                if (value_q == 32'd0) fe_d = 1'b1;
                else begin
                  it_d = value_q;
                  fv_d = 1'b1;
                end
              end
              CMD_SET_MASK: begin
                ie_d = value_q[NUM_INPUTS-1:0];
                fv_d = 1'b1;
              end
              CMD_SET_DELAY: begin
                ds_d = value_q[7:0];
                fv_d = 1'b1;
              end
              CMD_CLEAR: begin
                clr_d = 1'b1;
                fv_d  = 1'b1;
              end
              default: fe_d = 1'b1;
            endcase
          end
        end
        default: state_d = P_SYNC;
      endcase
    end else if (state_q != P_SYNC && (byte_ferr || gap_q == GAP_LIMIT)) begin
      // Framing error or stalled host aborts the partial frame.
      fe_d    = 1'b1;
      state_d = P_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= P_SYNC;
      cmd_q   <= 8'd0;
      value_q <= 32'd0;
      cnt_q   <= 2'd0;
      chk_q   <= 8'd0;
      gap_q   <= '0;
      it_q    <= 32'd50000000;
      ie_q    <= '1;
      ds_q    <= 8'd0;
      clr_q   <= 1'b0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      gap_q   <= gap_d;
      it_q    <= it_d;
      ie_q    <= ie_d;
      ds_q    <= ds_d;
      clr_q   <= clr_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign integration_time = it_q;
  assign input_enable     = ie_q;
  assign delay_sel        = ds_q;
  assign counters_clear   = clr_q;
  assign frame_valid      = fv_q;
  assign frame_error      = fe_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx with a frame-level reference model
module tb_uart_cmd_rx;

  localparam int CLK_HZ = 12500000;
  localparam int BAUD   = 230400;
  localparam int BD     = CLK_HZ / BAUD;      // 54 cycles per bit (54.25 truncated)
  localparam int TO     = 4 * 10 * BD;        // timeout gap in cycles
  localparam logic [31:0] RST_INT = 32'd50000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] integration_time;
  logic [11:0] input_enable;
  logic [7:0]  delay_sel;
  logic        counters_clear, frame_valid, frame_error;

  uart_cmd_rx #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .NUM_INPUTS   (12),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .RX              (rx),
    .integration_time(integration_time),
    .input_enable    (input_enable),
    .delay_sel       (delay_sel),
    .counters_clear  (counters_clear),
    .frame_valid     (frame_valid),
    .frame_error     (frame_error)
  );

  always #40 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_fv = 0, n_fe = 0, n_clr = 0;

  typedef struct {
    bit          is_valid;
    logic [31:0] it;
    logic [11:0] ie;
    logic [7:0]  ds;
    bit          clr;
    int          min_c;
    int          max_c;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] exp_it, sched_it;
  logic [11:0] exp_ie, sched_ie;
  logic [7:0]  exp_ds, sched_ds;
  bit          exp_clr;
  bit          collecting;
  logic [7:0]  frame[$];
  int          last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit v, input bit c, input int lo, input int hi);
    ev_t e;
    e.is_valid = v;
    e.it = sched_it;
    e.ie = sched_ie;
    e.ds = sched_ds;
    e.clr = c;
    e.min_c = lo;
    e.max_c = hi;
    evq.push_back(e);
  endtask

  // Frame-level model: called as each byte's stop bit begins.
  task automatic model_byte(input logic [7:0] b, input bit ferr);
    logic [7:0]  x;
    logic [31:0] val;
    bit          ok;
    last_push = cyc;
    if (ferr) begin
      if (collecting) push_ev(1'b0, 1'b0, cyc, cyc + BD + 20);
      collecting = 1'b0;
      frame.delete();
    end else if (!collecting) begin
      if (b == 8'hA5) begin
        collecting = 1'b1;
        frame.delete();
      end
    end else begin
      frame.push_back(b);
      if (frame.size() == 6) begin
        x   = frame[0] ^ frame[1] ^ frame[2] ^ frame[3] ^ frame[4];
        val = {frame[1], frame[2], frame[3], frame[4]};
        ok  = (x == frame[5]) && (frame[0] >= 8'd1) && (frame[0] <= 8'd4) &&
              !(frame[0] == 8'd1 && val == 32'd0);
        if (ok) begin
          if (frame[0] == 8'd1) sched_it = val;
          if (frame[0] == 8'd2) sched_ie = val[11:0];
          if (frame[0] == 8'd3) sched_ds = val[7:0];
        end
        push_ev(ok, ok && frame[0] == 8'd4, cyc, cyc + BD + 20);
        collecting = 1'b0;
        frame.delete();
      end
    end
  endtask

  task automatic model_timeout();
    if (collecting) push_ev(1'b0, 1'b0, last_push + TO, last_push + TO + BD + 20);
    collecting = 1'b0;
    frame.delete();
  endtask

  // Compare process: every cycle outside reset.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        evq.delete();
        exp_it = RST_INT;  sched_it = RST_INT;
        exp_ie = 12'hFFF;  sched_ie = 12'hFFF;
        exp_ds = 8'd0;     sched_ds = 8'd0;
        exp_clr = 1'b0;
        collecting = 1'b0;
        frame.delete();
      end else begin
        exp_clr = 1'b0;
        if (counters_clear) n_clr++;
        chk("valid_error_exclusive", {31'd0, frame_valid & frame_error}, 32'd0);
        if (frame_valid || frame_error) begin
          if (frame_valid) n_fv++;
          if (frame_error) n_fe++;
          if (evq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got fv=%0b fe=%0b expected none (cycle %0d)",
                     frame_valid, frame_error, cyc);
          end else begin
            e = evq.pop_front();
            chk("pulse_kind_valid", {31'd0, frame_valid}, {31'd0, e.is_valid});
            chk("pulse_not_early", {31'd0, cyc >= e.min_c}, 32'd1);
            if (e.is_valid) begin
              exp_it  = e.it;
              exp_ie  = e.ie;
              exp_ds  = e.ds;
              exp_clr = e.clr;
            end
          end
        end
        chk("integration_time", integration_time, exp_it);
        chk("input_enable", {20'd0, input_enable}, {20'd0, exp_ie});
        chk("delay_sel", {24'd0, delay_sel}, {24'd0, exp_ds});
        chk("counters_clear", {31'd0, counters_clear}, {31'd0, exp_clr});
        if (evq.size() > 0 && cyc > evq[0].max_c) begin
          checks++;
          failures++;
          $display("FAIL missing_pulse: got none expected %s by cycle %0d",
                   evq[0].is_valid ? "frame_valid" : "frame_error", evq[0].max_c);
          void'(evq.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    model_byte(b, !stopv);
    drive_bit(stopv);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] fr);
    for (int i = 0; i < 7; i++) send_byte(fr[55 - 8*i -: 8], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    chk("reset_integration_time", integration_time, 32'd50000000);
    chk("reset_input_enable", {20'd0, input_enable}, 32'hFFF);
    chk("reset_delay_sel", {24'd0, delay_sel}, 32'd0);
    chk("reset_pulses", {29'd0, counters_clear, frame_valid, frame_error}, 32'd0);

    // Set integration time to 1000.
    send_frame(56'hA5_01_00_00_03_E8_EA);
    idle(3 * BD);
    chk("t1_integration_time", integration_time, 32'd1000);
    chk("t1_input_enable", {20'd0, input_enable}, 32'hFFF);
    chk("t1_fv_count", n_fv, 32'd1);
    chk("t1_fe_count", n_fe, 32'd0);

    // Mask, then clear, back to back.
    send_frame(56'hA5_02_00_00_0F_0F_02);
    send_frame(56'hA5_04_00_00_00_00_04);
    idle(3 * BD);
    chk("t2_input_enable", {20'd0, input_enable}, 32'hF0F);
    chk("t2_clr_count", n_clr, 32'd1);
    chk("t2_fv_count", n_fv, 32'd3);

    // Bad checksum immediately followed by a good delay frame.
    send_frame(56'hA5_03_00_00_00_07_05);
    send_frame(56'hA5_03_00_00_00_07_04);
    idle(3 * BD);
    chk("t3_delay_sel", {24'd0, delay_sel}, 32'd7);
    chk("t3_fe_count", n_fe, 32'd1);
    chk("t3_fv_count", n_fv, 32'd4);

    // 1 us glitch, then framing error in the data field.
    rx = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    idle(3 * BD);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(3 * BD);
    chk("t4_fe_count", n_fe, 32'd2);
    chk("t4_integration_time", integration_time, 32'd1000);

    // Timeout after a partial frame; trailing bytes carry no sync.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    model_timeout();
    idle(TO + 10);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'hEA, 1'b1);
    idle(3 * BD);
    chk("t5_fe_count", n_fe, 32'd3);
    chk("t5_integration_time", integration_time, 32'd1000);

    // Reset for one cycle early in D1 of a valid frame.
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'hA5 : (i == 1 ? 8'h01 : 8'h00), 1'b1);
    fork
      send_byte(8'h03, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    send_byte(8'hE8, 1'b1);
    send_byte(8'hEA, 1'b1);
    idle(3 * BD);
    chk("t6_integration_time", integration_time, 32'd50000000);
    chk("t6_input_enable", {20'd0, input_enable}, 32'hFFF);
    chk("t6_delay_sel", {24'd0, delay_sel}, 32'd0);
    chk("t6_fv_count", n_fv, 32'd4);
    chk("t6_fe_count", n_fe, 32'd3);
    chk("events_drained", evq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
